// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative RV32M multiply/divide unit:
// FSM states, func3 op codes and the instruction fields that select M-ops.
package muldiv_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

endpackage

// File: rtl/ex_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, keep or restore. Purely combinational.
module ex_div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem_in,
  input  logic [W-1:0] quo_in,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_out,
  output logic [W-1:0] quo_out
);

  logic [W:0] trial;
  logic [W:0] diff;

  // Partial remainder stays below the divisor, so bit W of diff is a clean borrow.
  assign trial   = {rem_in, quo_in[W-1]};
  assign diff    = trial - {1'b0, divisor};
  assign rem_out = diff[W] ? trial[W-1:0] : diff[W-1:0];
  assign quo_out = {quo_in[W-2:0], ~diff[W]};

endmodule

// File: rtl/ex_muldiv.sv
// Iterative RV32M execute unit: radix-2 shift-add multiply / restoring divide
// on operand magnitudes, fixed 33-cycle start-to-done latency, pipeline stall.
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] Read1,
  input  logic [XLEN-1:0] Read2,
  input  logic [4:0]      rd,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      rd_out
);

  localparam int CW = $clog2(ITER + 1);

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q;
  logic [2:0]          op_q;
  logic [4:0]          rd_q;
  logic [2*XLEN-1:0]   p_q;
  logic [XLEN-1:0]     cand_q;
  logic [XLEN-1:0]     src1_q;
  logic                neg_q;
  logic                zero_q;
  logic [XLEN-1:0]     result_q;
  logic [4:0]          rd_out_q;

  logic                load, step, finish;
  logic                sgn1, sgn2, a_neg, b_neg, neg_d;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_next, p_step, prod;
  logic [XLEN-1:0]     div_rem, div_quo, div_val, res_d;

  ex_div_step #(.W(XLEN)) u_div_step (
    .rem_in  (p_q[2*XLEN-1:XLEN]),
    .quo_in  (p_q[XLEN-1:0]),
    .divisor (cand_q),
    .rem_out (div_rem),
    .quo_out (div_quo)
  );

  // Multiplier sits in the low half and shifts out as the product shifts in.
  assign mul_sum  = {1'b0, p_q[2*XLEN-1:XLEN]} + (p_q[0] ? {1'b0, cand_q} : '0);
  assign mul_next = {mul_sum, p_q[XLEN-1:1]};
  assign p_step   = (state_q == MUL) ? mul_next : {div_rem, div_quo};

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          load    = 1'b1;
          state_d = func3[2] ? DIV : MUL;
        end
        MUL, DIV: begin
          step = 1'b1;
          if (cnt_q == CW'(ITER - 1)) begin
            finish  = 1'b1;
            state_d = DONE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    if (func3[2]) begin
      sgn1 = ~func3[0];
      sgn2 = ~func3[0];
    end else begin
      sgn1 = (func3 == F3_MULH) | (func3 == F3_MULHSU);
      sgn2 = (func3 == F3_MULH);
    end
    a_neg = sgn1 & Read1[XLEN-1];
    b_neg = sgn2 & Read2[XLEN-1];
    a_mag = a_neg ? -Read1 : Read1;
    b_mag = b_neg ? -Read2 : Read2;
    // Remainder takes the dividend's sign; everything else the XOR of both.
    neg_d = (func3[2] & func3[1]) ? a_neg : (a_neg ^ b_neg);
  end

  always_comb begin
    prod    = neg_q ? -p_step : p_step;
    div_val = op_q[1] ? p_step[2*XLEN-1:XLEN] : p_step[XLEN-1:0];
    div_val = neg_q ? -div_val : div_val;
    res_d   = '0;
    if (!op_q[2]) begin
      res_d = (op_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end else if (zero_q) begin
      res_d = op_q[1] ? src1_q : '1;
    end else begin
      res_d = div_val;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      p_q      <= '0;
      cand_q   <= '0;
      src1_q   <= '0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
      result_q <= '0;
      rd_out_q <= '0;
    end else if (load) begin
      cnt_q  <= '0;
      op_q   <= func3;
      rd_q   <= rd;
      p_q    <= {{XLEN{1'b0}}, (func3[2] ? a_mag : b_mag)};
      cand_q <= func3[2] ? b_mag : a_mag;
      src1_q <= Read1;
      neg_q  <= neg_d;
      zero_q <= (Read2 == '0);
    end else if (step) begin
      cnt_q <= cnt_q + 1'b1;
      p_q   <= p_step;
      if (finish) begin
        result_q <= res_d;
        rd_out_q <= rd_q;
      end
    end
  end

  assign stall  = rst & (((state_q == IDLE) & start & ~flush) |
                         (state_q == MUL) | (state_q == DIV));
  assign done   = (state_q == DONE);
  assign result = result_q;
  assign rd_out = rd_out_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed and random bench for ex_muldiv against an arithmetic reference model.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  func3 = '0;
  logic [31:0] Read1 = '0;
  logic [31:0] Read2 = '0;
  logic [4:0]  rd = '0;
  logic        flush = 1'b0;
  logic        stall, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int compared = 0;
  int mismatched = 0;

  ex_muldiv #(.XLEN(32), .ITER(32)) dut (
    .clk(clk), .rst(rst), .start(start), .func3(func3),
    .Read1(Read1), .Read2(Read2), .rd(rd), .flush(flush),
    .stall(stall), .done(done), .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    logic        ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op and check latency, result, destination and the single-cycle pulse.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] r);
    int n;
    @(negedge clk);
    start = 1'b1; func3 = f; Read1 = a; Read2 = b; rd = r;
    #1 chk({tag, "_stall_issue"}, 32'(stall), 32'd1);
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, 32'd32);
    chk({tag, "_result"}, result, ref_op(f, a, b));
    chk({tag, "_rd"}, 32'(rd_out), 32'(r));
    chk({tag, "_stall_done"}, 32'(stall), 32'd0);
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
  endtask

  initial begin
    int pulses;
    logic [2:0]  f;
    logic [31:0] a, b;

    // Reset held with start asserted: outputs quiet, no stall.
    start = 1'b1;
    #2;
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_rd", 32'(rd_out), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    run_op("mul_7x-3", 3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 5'd11);
    run_op("mulhu_ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    run_op("mulh_ff", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4);
    run_op("mulhsu", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5);
    run_op("div_-20_3", 3'd4, 32'hFFFF_FFEC, 32'd3, 5'd6);
    run_op("rem_-20_3", 3'd6, 32'hFFFF_FFEC, 32'd3, 5'd7);
    run_op("divu_by0", 3'd5, 32'd20, 32'd0, 5'd8);
    run_op("remu_by0", 3'd7, 32'd20, 32'd0, 5'd9);
    run_op("div_by0_neg", 3'd4, 32'hFFFF_FFEC, 32'd0, 5'd10);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13);

    // Flush and start together in IDLE: nothing is captured.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; func3 = 3'd0; Read1 = 32'd5; Read2 = 32'd5;
    #1 chk("flush_start_stall", 32'(stall), 32'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    count_done(40, pulses);
    chk("flush_start_no_done", pulses, 32'd0);

    // Flush a DIVU in flight at cycle 10.
    @(negedge clk);
    start = 1'b1; func3 = 3'd5; Read1 = 32'd1000; Read2 = 32'd7; rd = 5'd14;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("flush_mid_stall_before", 32'(stall), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_mid_stall", 32'(stall), 32'd0);
    chk("flush_mid_done", 32'(done), 32'd0);
    count_done(40, pulses);
    chk("flush_mid_no_done", pulses, 32'd0);
    run_op("mul_2x3", 3'd0, 32'd2, 32'd3, 5'd15);

    // Reset asserted at cycle 15 of a MUL.
    @(negedge clk);
    start = 1'b1; func3 = 3'd0; Read1 = 32'd9; Read2 = 32'd9; rd = 5'd16;
    @(negedge clk);
    repeat (14) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_result", result, 32'd0);
    chk("mid_rst_rd", 32'(rd_out), 32'd0);
    chk("mid_rst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    start = 1'b0;
    rst = 1'b1;
    count_done(40, pulses);
    chk("mid_rst_no_done", pulses, 32'd0);

    for (int i = 0; i < 24; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 15));
      if ($urandom_range(0, 3) == 0) a = -a;
      run_op($sformatf("rand%0d_f%0d", i, f), f, a, b, 5'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath width; only 32 is supported.
REQ-002 SHALL have parameter ITER, default 32, meaning iteration cycles per operation.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  ID_EX holds a valid RV32M op (opcode 0110011, funct7 0000001).
REQ-006 SHALL have port func3  input  3  M-op select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 SHALL have ports Read1, Read2  input  32 each  rs1/rs2 operands from ID_EX.
REQ-008 SHALL have port rd  input  5  destination register from ID_EX.
REQ-009 SHALL have port flush  input  1  abort in-flight op (branch or exception).
REQ-010 SHALL have port stall  output  1  freezes IF/ID and ID_EX while high.
REQ-011 SHALL have port done  output  1  one-cycle result-valid pulse.
REQ-012 SHALL have port result  output  32  op result, valid while done=1.
REQ-013 SHALL have port rd_out  output  5  destination of result, valid while done=1.

Function
REQ-014 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-015 In IDLE with start=1 and flush=0: SHALL capture func3, rd and operands; next state MUL for func3<4, else DIV; iteration counter cleared to 0.
REQ-016 SHALL drive stall combinationally = (state==IDLE & start & ~flush) | state==MUL | state==DIV; stall SHALL be 0 in DONE.
REQ-017 MUL/DIV SHALL perform one radix-2 step per cycle for exactly ITER cycles, then enter DONE; start-to-done latency SHALL be 33 cycles (start sampled at edge k, done high in the cycle after edge k+32).
REQ-018 DONE SHALL assert done=1 for exactly one cycle, ignore start, and return to IDLE.
REQ-019 Multiply: operands SHALL be sign-extended per func3 (MULH both signed, MULHSU rs1 signed, MULHU none); 64-bit product; MUL returns bits 31:0, MULH* return bits 63:32.
REQ-020 Divide: restoring division on magnitudes; quotient sign = sign(rs1) XOR sign(rs2) for DIV; remainder sign = sign(rs1) for REM; unsigned ops use raw operands.
REQ-021 Divide by zero: DIV/DIVU SHALL return 0xFFFFFFFF; REM/REMU SHALL return rs1.
REQ-022 Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV SHALL return 0x80000000, REM SHALL return 0.
REQ-023 Special cases SHALL take the same 33-cycle latency as normal ops.
REQ-024 flush=1 in any state SHALL force IDLE at the next edge with no done pulse; flush and start together in IDLE: flush wins, nothing captured.
REQ-025 result and rd_out SHALL hold their last value outside DONE; consumers SHALL qualify with done.

Reset
REQ-026 rst=0 SHALL immediately force state IDLE, counter 0, done=0, result=0, rd_out=0, all operand/accumulator registers 0.
REQ-027 stall SHALL be 0 while rst=0 regardless of start.
REQ-028 Reset deasserted mid-operation SHALL leave the aborted op discarded; first start after release begins a fresh op.

Structure
REQ-029 Shared package muldiv_pkg SHALL hold the state encoding, func3 op codes, OPCODE_OP=7'b0110011 and FUNCT7_MULDIV=7'b0000001.
REQ-030 SHALL instantiate one sub-module ex_div_step (single restoring subtract/shift step, combinational); multiply step stays inline.
REQ-031 Implementation SHALL be 120-400 lines, with no multiplier or divider primitives inferred.

Verification
REQ-032 MUL 7 x -3 (0x00000007, 0xFFFFFFFD) -> done at cycle 33, result 0xFFFFFFEB, rd_out as issued.
REQ-033 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> result 0xFFFFFFFE; MULH same operands -> 0x00000000.
REQ-034 DIV -20 / 3 -> 0xFFFFFFFA; REM -20 % 3 -> 0xFFFFFFFE; DIVU 20 / 0 -> 0xFFFFFFFF; REMU 20 % 0 -> 20.
REQ-035 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same -> 0.
REQ-036 Start DIVU, assert flush at cycle 10 -> IDLE next edge, stall 0, no done pulse; new MUL 2x3 then -> result 6.
REQ-037 Pull rst low at cycle 15 of a MUL -> done, result, rd_out, stall all 0 immediately; no done after release until a new start.
